md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo. Drives mfhi/mflo read data to the EX result mux.
- Exports `md_stall` to the hazard/stall controller. While an operation is in flight, the controller holds any D-stage HI/LO instruction until the result is committed.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage HI/LO instruction valid this cycle (already gated by the stall/flush logic).
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- rd_sel  input  1  0 = read LO, 1 = read HI.
- busy  output  1  high while a mult/div is in flight.
- md_stall  output  1  = busy | (start & op in 1..4); to stall controller.
- rd_data  output  32  committed HI or LO per rd_sel, combinational.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, busy=0, counter=0, HI=0, LO=0.
  - Pending result discarded; no commit afterwards.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1. Counter counts down to 1, then returns to IDLE.
- IDLE, start=1, op in 1..4, at edge t:
  - Latch A, B and op into internal operand registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - Result is computed into shadow registers (hi_tmp/lo_tmp), not into HI/LO.
  - busy is high for exactly N cycles after edge t (N = MULT_CYCLES or DIV_CYCLES).
  - At the edge where the counter is 1: HI/LO take the shadow values; busy falls.
  - New values are visible on HI/LO/rd_data in the first cycle with busy=0.
- IDLE, start=1, op=5 (mthi): HI<=A at that edge, single cycle, busy stays 0.
- IDLE, start=1, op=6 (mtlo): LO<=A at that edge, single cycle, busy stays 0.
- start=1 while BUSY: ignored entirely; no latch, no HI/LO write. The stall controller guarantees this does not occur.
- op=0 or op=7 with start=1: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0, div or divu): full busy period still elapses; HI and LO keep their previous values.
- md_stall:
  - Combinational.
  - Asserted in the start cycle of a mult/div so the following HI/LO instruction cannot slip past.
  - Not asserted for mthi/mtlo.
- rd_data always reflects the committed registers. mfhi/mflo never observes the shadow values.

Test Plan:
- Reset, then A=7, B=6, op=1 (mult), start pulse at t → md_stall=1 at t. busy=1 for cycles t+1..t+5, 0 at t+6. At t+6: HI=0, LO=42. HI/LO stay 0 during busy.
- A=0xFFFFFFFE (-2), B=3: op=1 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with op=2 → HI=0x00000002, LO=0xFFFFFFFA.
- A=-7 (0xFFFFFFF9), B=2, op=3 → after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Same operands with op=4 → LO=0x7FFFFFFC, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo (busy stays 0; rd_sel=1 gives 0x11 next cycle). Then op=3 with B=0 → 10 busy cycles, HI=0x11, LO=0x22 unchanged. Then 0x80000000/0xFFFFFFFF with op=3 → LO=0x80000000, HI=0.
- Start mult 3*3; assert start op=6 A=0x55 at busy cycle 2 → ignored. After completion LO=9, HI=0.
- Start div 100/7; assert reset at busy cycle 4 → busy=0 and HI=LO=0 immediately, and remain 0 for 15 further cycles.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are staged in shadow registers and committed to HI/LO when the busy count expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] rd_data,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic             wr_en_q, wr_en_d;

  logic        is_md_op;
  logic        is_div_op;
  logic        div_signed;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dividend, divisor;
  logic [31:0] q_raw, r_raw, quot, rem;
  logic [31:0] hi_res, lo_res;

  assign is_md_op   = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  assign is_div_op  = (op == OpDiv) || (op == OpDivu);
  assign div_signed = (op == OpDiv);

  assign prod_u = {32'b0, A} * {32'b0, B};
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN with a zero remainder.
  assign a_mag    = A[31] ? (~A + 32'd1) : A;
  assign b_mag    = B[31] ? (~B + 32'd1) : B;
  assign dividend = div_signed ? a_mag : A;
  assign divisor  = (B == 32'd0) ? 32'd1 : (div_signed ? b_mag : B);
  assign q_raw    = dividend / divisor;
  assign r_raw    = dividend % divisor;
  assign quot     = (div_signed && (A[31] ^ B[31])) ? (~q_raw + 32'd1) : q_raw;
  assign rem      = (div_signed && A[31]) ? (~r_raw + 32'd1) : r_raw;

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      OpMult:  {hi_res, lo_res} = prod_s;
      OpMultu: {hi_res, lo_res} = prod_u;
      OpDiv, OpDivu: begin
        hi_res = rem;
        lo_res = quot;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    wr_en_d  = wr_en_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_md_op) begin
            state_d  = StBusy;
            cnt_d    = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            hi_tmp_d = hi_res;
            lo_tmp_d = lo_res;
            // Divide by zero still occupies the unit but leaves HI/LO untouched.
            wr_en_d  = !(is_div_op && (B == 32'd0));
          end else if (op == OpMthi) begin
            hi_d = A;
          end else if (op == OpMtlo) begin
            lo_d = A;
          end
        end
      end
      StBusy: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (wr_en_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      wr_en_q  <= wr_en_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign md_stall = busy | (start & is_md_op);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign rd_data  = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected commits, a monitor checks them on busy fall.
module tb_md_unit;

  localparam int MultCycles = 5;
  localparam int DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        rd_sel = 1'b0;
  logic        busy, md_stall;
  logic [31:0] rd_data, HI, LO;

  md_unit #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .md_stall(md_stall),
    .rd_data (rd_data),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the architectural definition of each instruction.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint          p, q, r;
    longint unsigned pu;
    case (o)
      3'd1: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd2: begin
        pu = longint'(a) * longint'(b);
        hi = pu[63:32];
        lo = pu[31:0];
      end
      3'd3: if (b != 32'd0) begin
        q  = longint'($signed(a)) / longint'($signed(b));
        r  = longint'($signed(a)) % longint'($signed(b));
        hi = r[31:0];
        lo = q[31:0];
      end
      3'd4: if (b != 32'd0) begin
        hi = a % b;
        lo = a / b;
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endtask

  // Drives one start pulse; returns one clock after the issuing edge (+1 time unit).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   md;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    md    = (o >= 3'd1) && (o <= 3'd4);
    #1;
    chk("md_stall_on_start", {31'd0, md_stall}, {31'd0, md});
    model(o, a, b, m_hi, m_lo);
    if (md) begin
      e.hi     = m_hi;
      e.lo     = m_lo;
      e.cycles = (o >= 3'd3) ? DivCycles : MultCycles;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_idle: busy still 1 after 40 cycles, required 0");
    end
  endtask

  task automatic check_regs(input string name);
    rd_sel = 1'b1;
    #1;
    chk({name, "_rd_hi"}, rd_data, m_hi);
    rd_sel = 1'b0;
    #1;
    chk({name, "_rd_lo"}, rd_data, m_lo);
    chk({name, "_HI"}, HI, m_hi);
    chk({name, "_LO"}, LO, m_lo);
  endtask

  // Monitor: counts busy cycles and checks the committed result on every busy fall.
  initial begin : monitor
    int   bcnt = 0;
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt      = 0;
        busy_prev = 1'b0;
      end else begin
        if (busy) begin
          bcnt++;
        end else if (busy_prev) begin
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL spurious_commit: busy fell with no pending op, expected none");
          end else begin
            e = sb_q.pop_front();
            chk("commit_HI", HI, e.hi);
            chk("commit_LO", LO, e.lo);
            chk("busy_cycles", 32'(bcnt), 32'(e.cycles));
          end
          bcnt = 0;
        end
        busy_prev = busy;
      end
    end
  end

  initial begin : stim
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [31:0] old_hi, old_lo;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, md_stall}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    reset = 1'b0;

    // mult 7*6, HI/LO must not move while busy
    issue(3'd1, 32'd7, 32'd6);
    for (int i = 0; i < MultCycles - 1; i++) begin
      @(negedge clk);
      chk("mult_busy_hi", {31'd0, busy}, 32'd1);
      chk("mult_hold_LO", LO, 32'd0);
      chk("mult_hold_HI", HI, 32'd0);
    end
    wait_idle();
    check_regs("mult7x6");

    issue(3'd1, 32'hFFFF_FFFE, 32'd3); wait_idle(); check_regs("mult_neg");
    issue(3'd2, 32'hFFFF_FFFE, 32'd3); wait_idle(); check_regs("multu");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2); wait_idle(); check_regs("div_neg");
    issue(3'd4, 32'hFFFF_FFF9, 32'd2); wait_idle(); check_regs("divu");

    issue(3'd5, 32'h11, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    check_regs("mthi");
    issue(3'd6, 32'h22, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    check_regs("mtlo");
    issue(3'd3, 32'd1234, 32'd0); wait_idle(); check_regs("div_zero");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(); check_regs("div_ovf");

    // mtlo during busy must be ignored
    issue(3'd1, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'd6;
    A     = 32'h55;
    #1;
    chk("stall_while_busy", {31'd0, md_stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
    wait_idle();
    check_regs("ignored_mtlo");

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      issue(ro, ra, rb);
      wait_idle();
      check_regs("random");
    end

    // reset in the middle of a divide discards the pending result
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_HI", HI, 32'd0);
    chk("midreset_LO", LO, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
      chk("post_reset_HI", HI, 32'd0);
      chk("post_reset_LO", LO, 32'd0);
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
